// File: rtl/mac_rx_pkt_buf_if.sv
// PHY receive word stream and front-end beat stream of the receive packet buffer.
// The buffer connects through the slave modport; the PHY/arbiter side uses master.
interface mac_rx_pkt_buf_if #(
    parameter int PHY_W = 32,
    parameter int FE_W  = 256,
    parameter int LEN_W = 12
);
    localparam int BV_W = $clog2(PHY_W / 8);

    logic             rx_sop;
    logic             rx_eop;
    logic             rx_valid;
    logic [PHY_W-1:0] rx_data;
    logic [BV_W-1:0]  rx_bv;

    logic             arb_mac_rdy;
    logic             arb_valid;
    logic [LEN_W-1:0] mac_fe_pkt_len;
    logic             mac_fe_data_valid;
    logic             mac_fe_sop;
    logic             mac_fe_eop;
    logic [FE_W-1:0]  mac_fe_data;

    modport master (
        output rx_sop, rx_eop, rx_valid, rx_data, rx_bv, arb_mac_rdy,
        input  arb_valid, mac_fe_pkt_len, mac_fe_data_valid, mac_fe_sop, mac_fe_eop, mac_fe_data
    );

    modport slave (
        input  rx_sop, rx_eop, rx_valid, rx_data, rx_bv, arb_mac_rdy,
        output arb_valid, mac_fe_pkt_len, mac_fe_data_valid, mac_fe_sop, mac_fe_eop, mac_fe_data
    );
endinterface

// File: rtl/mac_rx_pkt_buf.sv
// Receive packet buffer: stores whole PHY-width packets in NUM_BUF slots and replays
// completed ones, in completion order, as FE_W-bit beats under valid/ready.
module mac_rx_pkt_buf #(
    parameter int PHY_W   = 32,
    parameter int FE_W    = 256,
    parameter int NUM_BUF = 2,
    parameter int MAX_LEN = 1536,
    parameter int LEN_W   = 12,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    mac_rx_pkt_buf_if.slave           bus,
    output logic [CNT_W-1:0]          drop_cnt_o,
    output logic [$clog2(NUM_BUF):0]  free_slots_o
);
    localparam int BPW       = PHY_W / 8;
    localparam int WPB       = FE_W / PHY_W;
    localparam int FE_B      = FE_W / 8;
    localparam int MAXW      = (MAX_LEN + BPW - 1) / BPW;
    localparam int MAX_BEATS = (MAXW + WPB - 1) / WPB;
    localparam int MEM_WORDS = MAX_BEATS * WPB;
    localparam int SLOT_W    = $clog2(NUM_BUF);
    localparam int FS_W      = SLOT_W + 1;
    localparam int WIDX_W    = $clog2(MAXW + 1);
    localparam int MIDX_W    = $clog2(MEM_WORDS);
    localparam int NB_W      = $clog2(MAX_BEATS + 1);

    // W_IDLE: waiting for sop | W_RECV: storing into wslot | W_DROP: discarding to eop
    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_e;

    wstate_e             wstate_q, wstate_d;
    logic [SLOT_W-1:0]   wslot_q, wslot_d;
    logic [WIDX_W-1:0]   widx_q, widx_d;
    logic [SLOT_W-1:0]   rr_q, rr_d;
    logic [NUM_BUF-1:0]  busy_q, busy_d;
    logic [FS_W-1:0]     free_q, free_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic [PHY_W-1:0]    mem_q [NUM_BUF][MEM_WORDS];
    logic [LEN_W-1:0]    slot_len_q [NUM_BUF];
    logic [WIDX_W-1:0]   slot_nw_q [NUM_BUF];
    logic [SLOT_W-1:0]   cq_q [NUM_BUF];
    logic [SLOT_W-1:0]   cq_rd_q, cq_wr_q;
    logic [FS_W-1:0]     cq_cnt_q;

    logic                fe_valid_q, fe_valid_d;
    logic                fe_sop_q, fe_sop_d;
    logic                fe_eop_q, fe_eop_d;
    logic [LEN_W-1:0]    fe_len_q, fe_len_d;
    logic [FE_W-1:0]     fe_data_q, fe_data_d;
    logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
    logic [NB_W-1:0]     beat_q, beat_d;
    logic [NB_W-1:0]     nbeats_q, nbeats_d;

    logic                sop_new, abort_rel, drop_inc, claim, wr_en, complete;
    logic [SLOT_W-1:0]   wr_slot, comp_slot, fslot, cand;
    logic [WIDX_W-1:0]   wr_idx, comp_nw;
    logic [LEN_W-1:0]    comp_len, last_bytes;
    logic [NUM_BUF-1:0]  avail;
    logic                found;

    logic                load, rd_rel, pop;
    logic [SLOT_W-1:0]   load_slot;
    logic [NB_W-1:0]     load_beat;
    logic [LEN_W-1:0]    load_len;

    assign last_bytes = (bus.rx_bv == '0) ? LEN_W'(BPW) : LEN_W'(bus.rx_bv);

    always_comb begin
        wstate_d  = wstate_q;
        wslot_d   = wslot_q;
        widx_d    = widx_q;
        rr_d      = rr_q;
        sop_new   = 1'b0;
        abort_rel = 1'b0;
        drop_inc  = 1'b0;
        claim     = 1'b0;
        wr_en     = 1'b0;
        wr_slot   = wslot_q;
        wr_idx    = widx_q;
        complete  = 1'b0;
        comp_slot = wslot_q;
        comp_len  = '0;
        comp_nw   = '0;
        avail     = ~busy_q;
        found     = 1'b0;
        fslot     = '0;
        cand      = '0;

        if (bus.rx_valid) begin
            unique case (wstate_q)
                W_RECV: begin
                    if (bus.rx_sop && !bus.rx_eop) begin
                        abort_rel = 1'b1;
                        drop_inc  = 1'b1;
                        sop_new   = 1'b1;
                    end else if (widx_q >= WIDX_W'(MAXW)) begin
                        abort_rel = 1'b1;
                        drop_inc  = 1'b1;
                        wstate_d  = bus.rx_eop ? W_IDLE : W_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        widx_d = widx_q + WIDX_W'(1);
                        if (bus.rx_eop) begin
                            complete = 1'b1;
                            comp_len = LEN_W'(widx_q) * LEN_W'(BPW) + last_bytes;
                            comp_nw  = widx_q + WIDX_W'(1);
                            wstate_d = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (bus.rx_sop)      sop_new  = 1'b1;
                    else if (bus.rx_eop) wstate_d = W_IDLE;
                end
                default: begin
                    if (bus.rx_sop) sop_new = 1'b1;
                end
            endcase
        end

        // An aborted slot is reusable by the sop that aborted it.
        if (abort_rel) avail[wslot_q] = 1'b1;
        for (int i = 0; i < NUM_BUF; i++) begin
            cand = rr_q + SLOT_W'(i);
            if (!found && avail[cand]) begin
                found = 1'b1;
                fslot = cand;
            end
        end

        if (sop_new) begin
            if (found) begin
                claim   = 1'b1;
                wr_en   = 1'b1;
                wr_slot = fslot;
                wr_idx  = '0;
                wslot_d = fslot;
                widx_d  = WIDX_W'(1);
                rr_d    = fslot + SLOT_W'(1);
                if (bus.rx_eop) begin
                    complete  = 1'b1;
                    comp_slot = fslot;
                    comp_len  = last_bytes;
                    comp_nw   = WIDX_W'(1);
                    wstate_d  = W_IDLE;
                end else begin
                    wstate_d = W_RECV;
                end
            end else begin
                drop_inc = 1'b1;
                wstate_d = bus.rx_eop ? W_IDLE : W_DROP;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (abort_rel) busy_d[wslot_q]   = 1'b0;
        if (rd_rel)    busy_d[rd_slot_q] = 1'b0;
        if (claim)     busy_d[fslot]     = 1'b1;
        free_d = free_q + FS_W'(abort_rel) + FS_W'(rd_rel) - FS_W'(claim);
        drop_d = (drop_inc && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_comb begin
        fe_valid_d = fe_valid_q;
        fe_sop_d   = fe_sop_q;
        fe_eop_d   = fe_eop_q;
        fe_len_d   = fe_len_q;
        fe_data_d  = fe_data_q;
        rd_slot_d  = rd_slot_q;
        beat_d     = beat_q;
        nbeats_d   = nbeats_q;
        load       = 1'b0;
        rd_rel     = 1'b0;
        pop        = 1'b0;
        load_slot  = rd_slot_q;
        load_beat  = '0;
        load_len   = '0;

        if (fe_valid_q && bus.arb_mac_rdy) begin
            if (beat_q == nbeats_q - NB_W'(1)) begin
                rd_rel = 1'b1;
                pop    = 1'b1;
                if (cq_cnt_q > FS_W'(1)) begin
                    load      = 1'b1;
                    load_slot = cq_q[cq_rd_q + SLOT_W'(1)];
                end else begin
                    fe_valid_d = 1'b0;
                end
            end else begin
                load      = 1'b1;
                load_beat = beat_q + NB_W'(1);
            end
        end else if (!fe_valid_q && cq_cnt_q != '0) begin
            load      = 1'b1;
            load_slot = cq_q[cq_rd_q];
        end

        if (load) begin
            load_len   = slot_len_q[load_slot];
            fe_valid_d = 1'b1;
            rd_slot_d  = load_slot;
            beat_d     = load_beat;
            nbeats_d   = NB_W'((int'(load_len) + FE_B - 1) / FE_B);
            fe_sop_d   = (load_beat == '0);
            fe_eop_d   = (load_beat == nbeats_d - NB_W'(1));
            fe_len_d   = load_len;
            // Words past the stored count read as zero, not as stale slot contents.
            for (int j = 0; j < WPB; j++) begin
                if (int'(load_beat) * WPB + j < int'(slot_nw_q[load_slot]))
                    fe_data_d[j*PHY_W +: PHY_W] = mem_q[load_slot][MIDX_W'(int'(load_beat) * WPB + j)];
                else
                    fe_data_d[j*PHY_W +: PHY_W] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wstate_q   <= W_IDLE;
            wslot_q    <= '0;
            widx_q     <= '0;
            rr_q       <= '0;
            busy_q     <= '0;
            free_q     <= FS_W'(NUM_BUF);
            drop_q     <= '0;
            cq_rd_q    <= '0;
            cq_wr_q    <= '0;
            cq_cnt_q   <= '0;
            fe_valid_q <= 1'b0;
            fe_sop_q   <= 1'b0;
            fe_eop_q   <= 1'b0;
            fe_len_q   <= '0;
            fe_data_q  <= '0;
            rd_slot_q  <= '0;
            beat_q     <= '0;
            nbeats_q   <= '0;
        end else begin
            wstate_q   <= wstate_d;
            wslot_q    <= wslot_d;
            widx_q     <= widx_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
            free_q     <= free_d;
            drop_q     <= drop_d;
            if (complete) cq_wr_q <= cq_wr_q + SLOT_W'(1);
            if (pop)      cq_rd_q <= cq_rd_q + SLOT_W'(1);
            cq_cnt_q   <= cq_cnt_q + FS_W'(complete) - FS_W'(pop);
            fe_valid_q <= fe_valid_d;
            fe_sop_q   <= fe_sop_d;
            fe_eop_q   <= fe_eop_d;
            fe_len_q   <= fe_len_d;
            fe_data_q  <= fe_data_d;
            rd_slot_q  <= rd_slot_d;
            beat_q     <= beat_d;
            nbeats_q   <= nbeats_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_slot][MIDX_W'(wr_idx)] <= bus.rx_data;
        if (complete) begin
            slot_len_q[comp_slot] <= comp_len;
            slot_nw_q[comp_slot]  <= comp_nw;
            cq_q[cq_wr_q]         <= comp_slot;
        end
    end

    assign bus.arb_valid         = (cq_cnt_q != '0);
    assign bus.mac_fe_data_valid = fe_valid_q;
    assign bus.mac_fe_sop        = fe_sop_q;
    assign bus.mac_fe_eop        = fe_eop_q;
    assign bus.mac_fe_pkt_len    = fe_len_q;
    assign bus.mac_fe_data       = fe_data_q;
    assign drop_cnt_o            = drop_q;
    assign free_slots_o          = free_q;
endmodule

// File: tb/tb_mac_rx_pkt_buf.sv
// Scoreboard bench for mac_rx_pkt_buf: expected beats are queued at stimulus time and
// a negedge monitor pops/compares on every transfer and checks hold stability.
module tb_mac_rx_pkt_buf;
    logic        clk;
    logic        reset;
    logic [15:0] drop_cnt;
    logic [1:0]  free_slots;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [11:0]  len;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    sent;

    mac_rx_pkt_buf_if #(.PHY_W(32), .FE_W(256), .LEN_W(12)) bus ();

    mac_rx_pkt_buf #(
        .PHY_W(32), .FE_W(256), .NUM_BUF(2), .MAX_LEN(1536), .LEN_W(12), .CNT_W(16)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .bus         (bus),
        .drop_cnt_o  (drop_cnt),
        .free_slots_o(free_slots)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int pid, input int idx);
        return {8'(pid), 8'(idx) ^ 8'hA5, 16'(idx)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pkt(input int pid, input int nbytes);
        beat_t b;
        int nw, nb, idx;
        nw = (nbytes + 3) / 4;
        nb = (nbytes + 31) / 32;
        for (int k = 0; k < nb; k++) begin
            b.data = '0;
            for (int j = 0; j < 8; j++) begin
                idx = k * 8 + j;
                if (idx < nw) b.data[j*32 +: 32] = word_of(pid, idx);
            end
            b.sop = (k == 0);
            b.eop = (k == nb - 1);
            b.len = 12'(nbytes);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_pkt(input int pid, input int nbytes, input bit gap);
        int nw;
        nw = (nbytes + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            if (gap && i == nw / 2) begin
                bus.rx_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.rx_valid = 1'b1;
            bus.rx_sop   = (i == 0);
            bus.rx_eop   = (i == nw - 1);
            bus.rx_data  = word_of(pid, i);
            bus.rx_bv    = (i == nw - 1) ? 2'(nbytes % 4) : 2'd0;
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        bus.rx_eop   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 600 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d beats still outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: compare each transferred beat against the scoreboard head.
    logic         hold;
    logic [255:0] hd;
    logic         hs, he;
    logic [11:0]  hl;
    beat_t        e;

    initial begin
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!(bus.mac_fe_data_valid && bus.mac_fe_data == hd && bus.mac_fe_sop == hs &&
                          bus.mac_fe_eop == he && bus.mac_fe_pkt_len == hl)) begin
                        errors++;
                        $display("FAIL hold_stable: valid=%0b sop=%0b eop=%0b len=%0d data=%h expected held sop=%0b eop=%0b len=%0d data=%h",
                                 bus.mac_fe_data_valid, bus.mac_fe_sop, bus.mac_fe_eop, bus.mac_fe_pkt_len,
                                 bus.mac_fe_data, hs, he, hl, hd);
                    end
                end
                if (bus.mac_fe_data_valid && bus.arb_mac_rdy) begin
                    hold = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got len=%0d sop=%0b eop=%0b, expected no beat",
                                 bus.mac_fe_pkt_len, bus.mac_fe_sop, bus.mac_fe_eop);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.mac_fe_data !== e.data || bus.mac_fe_sop !== e.sop ||
                            bus.mac_fe_eop !== e.eop || bus.mac_fe_pkt_len !== e.len) begin
                            errors++;
                            $display("FAIL beat: got sop=%0b eop=%0b len=%0d data=%h expected sop=%0b eop=%0b len=%0d data=%h",
                                     bus.mac_fe_sop, bus.mac_fe_eop, bus.mac_fe_pkt_len, bus.mac_fe_data,
                                     e.sop, e.eop, e.len, e.data);
                        end
                    end
                end else if (bus.mac_fe_data_valid) begin
                    hold = 1'b1;
                    hd   = bus.mac_fe_data;
                    hs   = bus.mac_fe_sop;
                    he   = bus.mac_fe_eop;
                    hl   = bus.mac_fe_pkt_len;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.rx_valid    = 1'b0;
        bus.rx_sop      = 1'b0;
        bus.rx_eop      = 1'b0;
        bus.rx_data     = '0;
        bus.rx_bv       = '0;
        bus.arb_mac_rdy = 1'b0;
        sent            = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",     64'(bus.mac_fe_data_valid), 64'd0);
        chk("rst_arb_valid", 64'(bus.arb_valid), 64'd0);
        chk("rst_len",       64'(bus.mac_fe_pkt_len), 64'd0);
        chk("rst_data_zero", 64'(bus.mac_fe_data == '0), 64'd1);
        chk("rst_drop",      64'(drop_cnt), 64'd0);
        chk("rst_free",      64'(free_slots), 64'd2);
        @(posedge clk); #1;
        reset = 1'b0;

        // 64-byte packet, latency and two beats
        bus.arb_mac_rdy = 1'b1;
        expect_pkt(1, 64);
        send_pkt(1, 64, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(bus.mac_fe_data_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(bus.mac_fe_data_valid), 64'd1);
        chk("lat_cycle2_sop",   64'(bus.mac_fe_sop), 64'd1);
        wait_drain("drain_64");

        // 61-byte packet with a gap mid-packet
        expect_pkt(2, 61);
        send_pkt(2, 61, 1'b1);
        wait_drain("drain_61");

        // Single-word packet
        expect_pkt(3, 3);
        send_pkt(3, 3, 1'b0);
        wait_drain("drain_3");
        chk("drop_before_full", 64'(drop_cnt), 64'd0);

        // Backpressure: third back-to-back packet dropped
        bus.arb_mac_rdy = 1'b0;
        expect_pkt(4, 64);
        expect_pkt(5, 64);
        send_pkt(4, 64, 1'b0);
        send_pkt(5, 64, 1'b0);
        send_pkt(6, 64, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("full_drop_cnt",  64'(drop_cnt), 64'd1);
        chk("full_free",      64'(free_slots), 64'd0);
        chk("full_arb_valid", 64'(bus.arb_valid), 64'd1);
        chk("full_fe_valid",  64'(bus.mac_fe_data_valid), 64'd1);
        bus.arb_mac_rdy = 1'b1;
        wait_drain("drain_full");
        repeat (2) @(posedge clk); #1;
        chk("full_free_after", 64'(free_slots), 64'd2);
        chk("full_arb_after",  64'(bus.arb_valid), 64'd0);

        // Ready toggling every cycle over a 256-byte packet
        expect_pkt(7, 256);
        sent = 1'b0;
        fork
            begin
                send_pkt(7, 256, 1'b0);
                sent = 1'b1;
            end
            begin
                for (int c = 0; c < 400; c++) begin
                    if (sent && exp_q.size() == 0) break;
                    @(posedge clk); #1;
                    bus.arb_mac_rdy = ~bus.arb_mac_rdy;
                end
            end
        join
        bus.arb_mac_rdy = 1'b1;
        wait_drain("drain_toggle");

        // Oversize packet dropped, then normal traffic resumes
        send_pkt(8, 1540, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("oversize_drop",  64'(drop_cnt), 64'd2);
        chk("oversize_free",  64'(free_slots), 64'd2);
        chk("oversize_valid", 64'(bus.mac_fe_data_valid), 64'd0);
        expect_pkt(9, 64);
        send_pkt(9, 64, 1'b0);
        wait_drain("drain_after_oversize");

        // Reset with one packet held and another in flight
        bus.arb_mac_rdy = 1'b0;
        send_pkt(10, 64, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_sop   = (i == 0);
            bus.rx_eop   = 1'b0;
            bus.rx_data  = word_of(11, i);
            bus.rx_bv    = 2'd0;
            @(posedge clk); #1;
        end
        chk("pre_rst_free",  64'(free_slots), 64'd0);
        chk("pre_rst_valid", 64'(bus.mac_fe_data_valid), 64'd1);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_sop   = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid",     64'(bus.mac_fe_data_valid), 64'd0);
        chk("mid_rst_arb_valid", 64'(bus.arb_valid), 64'd0);
        chk("mid_rst_sop_eop",   64'({bus.mac_fe_sop, bus.mac_fe_eop}), 64'd0);
        chk("mid_rst_len",       64'(bus.mac_fe_pkt_len), 64'd0);
        chk("mid_rst_data_zero", 64'(bus.mac_fe_data == '0), 64'd1);
        chk("mid_rst_drop",      64'(drop_cnt), 64'd0);
        chk("mid_rst_free",      64'(free_slots), 64'd2);
        @(posedge clk); #1;
        reset = 1'b0;

        bus.arb_mac_rdy = 1'b1;
        expect_pkt(12, 64);
        send_pkt(12, 64, 1'b0);
        wait_drain("drain_after_reset");
        repeat (2) @(posedge clk); #1;
        chk("final_free", 64'(free_slots), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_rx_pkt_buf.md
Name: mac_rx_pkt_buf

Overview:
Parametrised receive-side MAC packet buffer: accepts PHY-width word streams (sop/eop/valid/bv), stores whole packets in NUM_BUF slots, and forwards each completed packet to the arbiter/front-end as FE_W-bit beats under a valid/ready handshake.
It generalises the two-slot ping-pong receive path to N slots, configurable bus widths, oversize and overflow drop, and real backpressure.
Sits between the PHY receive interface and the switch arbiter.

Parameters:
PHY_W, 32, PHY data width in bits (multiple of 8, power of 2)
FE_W, 256, front-end beat width in bits (multiple of PHY_W)
NUM_BUF, 2, number of packet slots (power of 2, >=2)
MAX_LEN, 1536, maximum accepted packet length in bytes
LEN_W, 12, width of packet length fields
CNT_W, 16, width of drop counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
rx_sop  in  1  first PHY word of packet
rx_eop  in  1  last PHY word of packet
rx_valid  in  1  PHY word valid
rx_data  in  PHY_W  PHY word; byte 0 in bits [7:0]
rx_bv  in  clog2(PHY_W/8)  valid bytes in eop word; 0 means all PHY_W/8 bytes are valid
arb_mac_rdy  in  1  arbiter accepts the current beat
arb_valid  out  1  at least one complete packet is held
mac_fe_pkt_len  out  LEN_W  byte length of the packet being output
mac_fe_data_valid  out  1  beat valid
mac_fe_sop  out  1  first beat of packet
mac_fe_eop  out  1  last beat of packet
mac_fe_data  out  FE_W  beat data; lowest-index PHY word in bits [PHY_W-1:0]
drop_cnt  out  CNT_W  dropped-packet count, saturating
free_slots  out  clog2(NUM_BUF)+1  number of unclaimed slots

Behaviour:
- Derived values: BPW = PHY_W/8; WPB = FE_W/PHY_W; max words = ceil(MAX_LEN/BPW).
- Reset values: all outputs 0, except free_slots = NUM_BUF. Reset empties all slots, clears the completion queue and aborts any in-flight packet in either direction.
- Write FSM states: IDLE, RECV, DROP.
- IDLE:
  - rx_valid & rx_sop with free_slots > 0: claim the next slot in round-robin order, store word 0, go to RECV (or straight to completion if rx_eop is also set).
  - rx_valid & rx_sop with no free slot: go to DROP and increment drop_cnt.
  - rx_valid without rx_sop: ignored.
- RECV:
  - Each rx_valid stores a word at index widx and increments widx.
  - A word with index >= max words: release the slot, increment drop_cnt, go to DROP (or IDLE if rx_eop is set on that word).
  - rx_valid & rx_sop without rx_eop: abort the current packet (release slot, increment drop_cnt), then handle the word as a new sop from IDLE in the same cycle.
  - rx_valid & rx_eop: len = widx*BPW + (rx_bv==0 ? BPW : rx_bv). Mark the slot complete, push its index onto the completion queue (depth NUM_BUF), go to IDLE.
- DROP: discard words until rx_valid & rx_eop, then go to IDLE. A sop seen in DROP is treated as in IDLE.
- rx_valid low: hold state; gaps inside a packet are legal.
- Read side:
  - arb_valid = completion queue non-empty.
  - Packets are output in completion order.
  - Beats per packet = ceil(len/(FE_W/8)). Beat k carries words k*WPB .. k*WPB+WPB-1.
  - Words at index >= stored word count are driven 0. Bytes above len inside the last stored word are passed as received.
  - mac_fe_sop is high on beat 0 only; mac_fe_eop is high on the last beat only; both are high for a single-beat packet.
  - mac_fe_pkt_len is constant for every beat of a packet.
- Handshake:
  - A beat transfers when mac_fe_data_valid & arb_mac_rdy.
  - While valid and not ready, data, sop, eop and len are held stable.
  - Valid never drops until the beat transfers.
  - The next packet's beat 0 may follow the previous eop beat with no gap.
- Latency: with the output idle, beat 0 is valid exactly 2 cycles after the cycle rx_eop is sampled.
- Slot release:
  - The slot is freed, and free_slots incremented, in the cycle after its eop beat transfers.
  - A sop sampled in the same cycle as that transfer sees the old free_slots value.
  - Simultaneous claim and release leave free_slots unchanged.
- drop_cnt saturates at all-ones.

Test Plan:
- 64-byte packet (16 words, rx_bv=0), arb_mac_rdy=1 -> 2 beats; sop on beat 0, eop on beat 1; len=64; beat 0 valid 2 cycles after eop.
- 61-byte packet (16 words, last rx_bv=1) -> len=61, 2 beats; top byte lanes of word 15 as received.
- Single word with sop=eop=1 and rx_bv=3 -> len=3, 1 beat with sop=eop=1; words 1..7 = 0.
- NUM_BUF=2, arb_mac_rdy=0, three back-to-back 64-byte packets -> third dropped; drop_cnt=1; free_slots=0. Then arb_mac_rdy=1 -> packets 1 and 2 output in order; free_slots returns to 2.
- arb_mac_rdy toggled 1/0 every cycle over a 256-byte packet -> 8 beats; each beat held stable while not ready; no beat lost or duplicated.
- 1540-byte packet -> dropped, drop_cnt+1, slot released, next 64-byte packet output correctly. Separately, assert reset mid-packet -> all outputs 0 and free_slots=NUM_BUF immediately.
